banco_almacenamiento: RTL and testbench
=======================================

# banco_almacenamiento

Multi-slot storage bank for stopwatch limit values entered from the keyboard. Captures a DIGITS-wide digit word into the next free slot once per save keypress, keeps per-slot valid flags, and serves a registered readout of any slot to the comparator and display logic. Sits between the keyboard scan-code decoder and the stopwatch comparison block. It is the parametrised successor of the single three-digit storage register.

## Interface
Parameters:
- DIGITS, 3, digits per stored value
- DIG_W, 8, bits per digit
- SLOTS, 4, number of storage slots (≥2)
- SAVE_KEY, 8'h75, scan code that triggers a save
- CLEAR_KEY, 8'h71, scan code that clears the bank (only with BANCO_CLEAR_EN)
- SLOT_W (localparam), $clog2(SLOTS), slot index width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- dato  in  DIGITS*DIG_W  digit word; digit 0 in LSBs
- tecla  in  8  current scan code from keyboard decoder, held while key down
- guardar  in  1  save/clear enable; commands ignored when 0
- sel_lect  in  SLOT_W  slot to read out
- salida  out  DIGITS*DIG_W  registered contents of slot sel_lect
- valido  out  SLOTS  bit i = slot i holds a saved value
- ptr  out  SLOT_W  slot the next save writes
- guardado  out  1  one-cycle pulse per accepted save
- lleno  out  1  all valido bits set
- AAA  out  1  sticky: at least one save accepted since reset/clear

## Operation
- FSM states: IDLE, WAIT_REL.
- IDLE, tecla==SAVE_KEY and guardar==1: mem[ptr]<=dato, valido[ptr]<=1, ptr<=ptr+1 (wraps SLOTS-1 -> 0), guardado<=1, AAA<=1, go WAIT_REL.
- WAIT_REL: no command accepted; return to IDLE on first cycle tecla!=SAVE_KEY (and !=CLEAR_KEY). A held key saves exactly once.
- Full bank (lleno=1): save still accepted, overwrites slot ptr (oldest), valido unchanged.
- guardar==0: key ignored, FSM stays IDLE.
- Readout: salida<=(sel_lect<SLOTS && valido[sel_lect]) ? mem[sel_lect] : 0, every cycle.
- lleno = &valido (combinational from registered flags).

## Timing
- Reset (reset=0, async): mem, salida, valido, ptr, guardado, AAA all 0; FSM IDLE. Deassertion takes effect at the next clk edge.
- Save sampled at edge k: mem/valido/ptr/AAA updated at k; guardado high for cycle k..k+1 only.
- Readout latency 1 cycle from sel_lect change. Save into currently selected slot: salida shows old value (or 0 if previously invalid) after edge k, new value after edge k+1.
- Reset asserted while in WAIT_REL: returns to IDLE; a key still held after release of reset triggers a new save.
- sel_lect ≥ SLOTS (non-power-of-2 SLOTS): salida=0.

## Configuration
- BANCO_CLEAR_EN defined: in IDLE, tecla==CLEAR_KEY and guardar==1 clears valido, ptr, AAA to 0, go WAIT_REL (held key clears once); mem contents kept but invisible (salida=0). No guardado pulse. Clear has priority only because SAVE_KEY≠CLEAR_KEY; SAVE_KEY==CLEAR_KEY is illegal.
- Not defined: CLEAR_KEY ignored; valido/ptr/AAA only return to 0 via reset.

## Test plan
- Reset then idle: all outputs 0, salida=0 for every sel_lect.
- dato=24'h010203, tecla=8'h75 held 10 cycles, guardar=1 -> one guardado pulse, valido=4'b0001, ptr=1, AAA=1, sel_lect=0 gives salida=24'h010203 next cycle.
- Five separate save presses with dato 1..5 (SLOTS=4) -> lleno=1 after 4th; 5th overwrites slot 0 with 5, ptr=1, valido=4'b1111.
- tecla=8'h75 with guardar=0 -> no state change; raise guardar while key held -> single save.
- Save into selected slot while sel_lect=ptr -> salida old value one cycle, new value next cycle; reset asserted mid-WAIT_REL -> IDLE, all cleared.
- With BANCO_CLEAR_EN: two saves, then tecla=8'h71, guardar=1 -> valido=0, ptr=0, AAA=0, salida=0; without macro same stimulus -> no change.

Source files
------------

// File: rtl/banco_almacenamiento.sv
// Purpose: multi-slot store for keyboard-entered stopwatch limits; one save per keypress into the next slot.
// Latency: save updates mem/valido/ptr/AAA at the sampling edge; salida is registered, 1 cycle after sel_lect.
// Backpressure: none; a held key is consumed once, then ignored until it is released.
//
// Ports:
//   clk, reset (async, active-low)
//   dato      digit word to store, digit 0 in the LSBs
//   tecla     scan code from the keyboard decoder, held while the key is down
//   guardar   command enable; save/clear keys are ignored while low
//   sel_lect  slot to read out
//   salida    registered contents of slot sel_lect (0 if invalid or out of range)
//   valido    per-slot valid flags
//   ptr       slot the next save writes
//   guardado  one-cycle pulse per accepted save
//   lleno     all slots valid
//   AAA       sticky: at least one save since reset/clear
//
// Optional feature macro: BANCO_CLEAR_EN enables CLEAR_KEY to empty the bank.

module banco_almacenamiento #(
  parameter int          DIGITS    = 3,
  parameter int          DIG_W     = 8,
  parameter int          SLOTS     = 4,
  parameter logic [7:0]  SAVE_KEY  = 8'h75,
  parameter logic [7:0]  CLEAR_KEY = 8'h71,
  localparam int         SLOT_W    = $clog2(SLOTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DIGITS*DIG_W-1:0] dato,
  input  logic [7:0]              tecla,
  input  logic                    guardar,
  input  logic [SLOT_W-1:0]       sel_lect,
  output logic [DIGITS*DIG_W-1:0] salida,
  output logic [SLOTS-1:0]        valido,
  output logic [SLOT_W-1:0]       ptr,
  output logic                    guardado,
  output logic                    lleno,
  output logic                    AAA
);

  localparam int W = DIGITS * DIG_W;

  typedef enum logic {IDLE, WAIT_REL} state_t;

  state_t            state, state_nxt;
  logic [W-1:0]      mem [SLOTS];
  logic              do_save;
  logic [SLOT_W-1:0] ptr_nxt;
  logic              rd_ok;
`ifdef BANCO_CLEAR_EN
  logic              do_clear;
`endif

  // Next-state and command decode. A command is only taken in IDLE, so a
  // held key acts once; WAIT_REL waits for any non-command code.
  always_comb begin
    state_nxt = state;
    do_save   = 1'b0;
`ifdef BANCO_CLEAR_EN
    do_clear  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (guardar && tecla == SAVE_KEY) begin
          do_save   = 1'b1;
          state_nxt = WAIT_REL;
        end
`ifdef BANCO_CLEAR_EN
        else if (guardar && tecla == CLEAR_KEY) begin
          do_clear  = 1'b1;
          state_nxt = WAIT_REL;
        end
`endif
      end
      WAIT_REL: begin
        if (tecla != SAVE_KEY && tecla != CLEAR_KEY)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Wrapping write pointer; once full, the next save overwrites the oldest slot.
  assign ptr_nxt = (ptr == SLOT_W'(SLOTS - 1)) ? '0 : ptr + SLOT_W'(1);

  // With a non-power-of-2 slot count some sel_lect codes name no slot.
  generate
    if (SLOTS == (1 << SLOT_W)) begin : g_rd_full
      assign rd_ok = valido[sel_lect];
    end else begin : g_rd_part
      assign rd_ok = (sel_lect < SLOT_W'(SLOTS)) && valido[sel_lect];
    end
  endgenerate

  assign lleno = &valido;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      for (int i = 0; i < SLOTS; i++) mem[i] <= '0;
      salida   <= '0;
      valido   <= '0;
      ptr      <= '0;
      guardado <= 1'b0;
      AAA      <= 1'b0;
    end else begin
      state    <= state_nxt;
      guardado <= do_save;
      // Reads the pre-edge memory, so a save into the selected slot shows
      // up one cycle later than the write.
      salida   <= rd_ok ? mem[sel_lect] : '0;
      if (do_save) begin
        mem[ptr]    <= dato;
        valido[ptr] <= 1'b1;
        ptr         <= ptr_nxt;
        AAA         <= 1'b1;
      end
`ifdef BANCO_CLEAR_EN
      else if (do_clear) begin
        // Memory contents are left in place; cleared flags hide them.
        valido <= '0;
        ptr    <= '0;
        AAA    <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_banco_almacenamiento.sv
// Purpose: self-checking bench for banco_almacenamiento (default parameters, SLOTS=4).
// Latency: each vector is driven after a clock edge and its outputs sampled 1 time unit after the next edge.
// Backpressure: not applicable; stimulus is driven unconditionally.

module tb_banco_almacenamiento;

`ifdef BANCO_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] dato;
  logic [7:0]  tecla;
  logic        guardar;
  logic [1:0]  sel_lect;
  logic [23:0] salida;
  logic [3:0]  valido;
  logic [1:0]  ptr;
  logic        guardado;
  logic        lleno;
  logic        AAA;

  int n_vec = 0;
  int n_err = 0;

  banco_almacenamiento dut (
    .clk      (clk),
    .reset    (reset),
    .dato     (dato),
    .tecla    (tecla),
    .guardar  (guardar),
    .sel_lect (sel_lect),
    .salida   (salida),
    .valido   (valido),
    .ptr      (ptr),
    .guardado (guardado),
    .lleno    (lleno),
    .AAA      (AAA)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tecla;
    logic        guardar;
    logic [23:0] dato;
    logic [1:0]  sel;
    logic [3:0]  v;
    logic [1:0]  p;
    logic        gd;
    logic        a;
    logic        l;
    logic [23:0] s;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic add(input logic [7:0] t, input logic g, input logic [23:0] d,
                     input logic [1:0] sel, input logic [3:0] v, input logic [1:0] p,
                     input logic gd, input logic a, input logic l, input logic [23:0] s);
    vec_t x;
    x.tecla = t; x.guardar = g; x.dato = d; x.sel = sel;
    x.v = v; x.p = p; x.gd = gd; x.a = a; x.l = l; x.s = s;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one vector, push its expectation, and compare after the next edge.
  task automatic apply(input vec_t x, input int idx);
    vec_t e;
    exp_q.push_back(x);
    tecla = x.tecla; guardar = x.guardar; dato = x.dato; sel_lect = x.sel;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("v%0d valido", idx),   32'(valido),   32'(e.v));
    chk($sformatf("v%0d ptr", idx),      32'(ptr),      32'(e.p));
    chk($sformatf("v%0d guardado", idx), 32'(guardado), 32'(e.gd));
    chk($sformatf("v%0d AAA", idx),      32'(AAA),      32'(e.a));
    chk($sformatf("v%0d lleno", idx),    32'(lleno),    32'(e.l));
    chk($sformatf("v%0d salida", idx),   32'(salida),   32'(e.s));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " salida"},   32'(salida),   32'd0);
    chk({tag, " valido"},   32'(valido),   32'd0);
    chk({tag, " ptr"},      32'(ptr),      32'd0);
    chk({tag, " guardado"}, 32'(guardado), 32'd0);
    chk({tag, " AAA"},      32'(AAA),      32'd0);
    chk({tag, " lleno"},    32'(lleno),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t hold;
    // Idle after reset: nothing valid, every slot reads 0.
    for (int i = 0; i < 4; i++) add(8'h00, 1, 24'h0, 2'(i), 4'h0, 0, 0, 0, 0, 24'h0);
    // Save held for 10 cycles: exactly one pulse.
    add(8'h75, 1, 24'h010203, 0, 4'h1, 1, 1, 1, 0, 24'h0);
    for (int i = 0; i < 9; i++) add(8'h75, 1, 24'h010203, 0, 4'h1, 1, 0, 1, 0, 24'h010203);
    add(8'h00, 1, 24'h0, 0, 4'h1, 1, 0, 1, 0, 24'h010203);
    // Key with guardar low is ignored; raising guardar while held saves once.
    add(8'h75, 0, 24'h000002, 0, 4'h1, 1, 0, 1, 0, 24'h010203);
    add(8'h75, 0, 24'h000002, 0, 4'h1, 1, 0, 1, 0, 24'h010203);
    add(8'h75, 1, 24'h000002, 1, 4'h3, 2, 1, 1, 0, 24'h0);
    add(8'h75, 1, 24'h000002, 1, 4'h3, 2, 0, 1, 0, 24'h000002);
    add(8'h00, 1, 24'h0,      1, 4'h3, 2, 0, 1, 0, 24'h000002);
    // Saves into the currently selected slot: old value first, new one next.
    add(8'h75, 1, 24'h000003, 2, 4'h7, 3, 1, 1, 0, 24'h0);
    add(8'h00, 1, 24'h0,      2, 4'h7, 3, 0, 1, 0, 24'h000003);
    add(8'h75, 1, 24'h000004, 3, 4'hF, 0, 1, 1, 1, 24'h0);
    add(8'h00, 1, 24'h0,      3, 4'hF, 0, 0, 1, 1, 24'h000004);
    // Fifth save on a full bank overwrites slot 0.
    add(8'h75, 1, 24'h000005, 0, 4'hF, 1, 1, 1, 1, 24'h010203);
    add(8'h00, 1, 24'h0,      0, 4'hF, 1, 0, 1, 1, 24'h000005);
    // Clear key: empties the bank only when the feature is built in.
    add(8'h71, 1, 24'h0, 0, CLR ? 4'h0 : 4'hF, CLR ? 2'd0 : 2'd1, 0, !CLR, !CLR, 24'h000005);
    add(8'h00, 1, 24'h0, 1, CLR ? 4'h0 : 4'hF, CLR ? 2'd0 : 2'd1, 0, !CLR, !CLR,
        CLR ? 24'h0 : 24'h000002);
    // Next save lands at ptr; leaves the FSM in WAIT_REL with the key held.
    add(8'h75, 1, 24'h0000AA, 0, CLR ? 4'h1 : 4'hF, CLR ? 2'd1 : 2'd2, 1, 1, !CLR,
        CLR ? 24'h0 : 24'h000005);

    reset = 1'b0; tecla = 8'h00; guardar = 1'b0; dato = '0; sel_lect = '0;
    #3;
    chk_zero("reset");
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Reset while in WAIT_REL with the save key still held.
    reset = 1'b0;
    #1;
    chk_zero("midreset");
    dato = 24'h000077;
    @(negedge clk);
    reset = 1'b1;
    hold.tecla = 8'h75; hold.guardar = 1; hold.dato = 24'h000077; hold.sel = 0;
    hold.v = 4'h1; hold.p = 1; hold.gd = 1; hold.a = 1; hold.l = 0; hold.s = 24'h0;
    apply(hold, 100);
    hold.gd = 0; hold.s = 24'h000077;
    apply(hold, 101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
